// File: rtl/lcv_mul_acc_arb_pkg.sv
// Shared constants and result-buffer entry type for the shared multiply-accumulate arbiter.
package lcv_mul_acc_arb_pkg;

    localparam int MAC_A_W      = 16;
    localparam int MAC_ACC_W    = 33;
    localparam int MAC_LAT      = 1;
    // Widest id tag supported (NUM_REQ up to 16); narrower ids are zero-extended.
    localparam int RSP_ID_MAX_W = 4;

    typedef struct packed {
        logic [RSP_ID_MAX_W-1:0] id;
        logic [MAC_ACC_W-1:0]    data;
    } rsp_entry_t;

endpackage

// File: rtl/lcv_mac33.sv
// Registered signed datapath: acc = a*b + c + d + e, wrapped to 33 bits, one cycle latency.
module lcv_mac33
    import lcv_mul_acc_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [MAC_A_W-1:0]   a_i,
    input  logic signed [MAC_A_W-1:0]   b_i,
    input  logic signed [MAC_ACC_W-1:0] c_i,
    input  logic signed [MAC_ACC_W-1:0] d_i,
    input  logic signed [MAC_ACC_W-1:0] e_i,
    output logic signed [MAC_ACC_W-1:0] acc_o
);

    localparam int PROD_W = 2 * MAC_A_W;

    logic signed [PROD_W-1:0]    prod;
    logic signed [MAC_ACC_W-1:0] acc_d;
    logic signed [MAC_ACC_W-1:0] acc_q;

    assign prod  = PROD_W'(a_i) * PROD_W'(b_i);
    assign acc_d = $signed({prod[PROD_W-1], prod}) + c_i + d_i + e_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/lcv_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the priority pointer wins; pointer moves past it on advance.
module lcv_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W:0]   cand;
    logic            found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[ID_W-1:0]]) begin
                found       = 1'b1;
                grant_idx_o = cand[ID_W-1:0];
            end
        end
        if (en_i && found) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            if (grant_idx_o == ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lcv_mul_acc_arbiter.sv
// Shares one registered MAC among NUM_REQ requesters; results return in accept order through
// a 2-entry buffer, and issue is credit-gated because the MAC itself cannot stall.
module lcv_mul_acc_arbiter
    import lcv_mul_acc_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*16-1:0]  req_a,
    input  logic [NUM_REQ*16-1:0]  req_b,
    input  logic [NUM_REQ*33-1:0]  req_c,
    input  logic [NUM_REQ*33-1:0]  req_d,
    input  logic [NUM_REQ*33-1:0]  req_e,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [32:0]            rsp_data,
    output logic                   busy
);

    logic signed [MAC_A_W-1:0]   a_arr [NUM_REQ];
    logic signed [MAC_A_W-1:0]   b_arr [NUM_REQ];
    logic signed [MAC_ACC_W-1:0] c_arr [NUM_REQ];
    logic signed [MAC_ACC_W-1:0] d_arr [NUM_REQ];
    logic signed [MAC_ACC_W-1:0] e_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[MAC_A_W*gi +: MAC_A_W];
        assign b_arr[gi] = req_b[MAC_A_W*gi +: MAC_A_W];
        assign c_arr[gi] = req_c[MAC_ACC_W*gi +: MAC_ACC_W];
        assign d_arr[gi] = req_d[MAC_ACC_W*gi +: MAC_ACC_W];
        assign e_arr[gi] = req_e[MAC_ACC_W*gi +: MAC_ACC_W];
    end

    logic [NUM_REQ-1:0]          grant;
    logic [ID_W-1:0]             grant_idx;
    logic                        accept;
    logic                        can_issue;
    logic                        pop;
    logic                        push;
    logic signed [MAC_ACC_W-1:0] mac_acc;

    logic                        pend_valid_q, pend_valid_d;
    logic [ID_W-1:0]             pend_id_q, pend_id_d;
    logic [1:0]                  occ_q, occ_d;
    logic                        head_q, head_d;
    logic                        tail_q, tail_d;
    rsp_entry_t                  buf_q [BUF_DEPTH];
    rsp_entry_t                  head_entry;
    rsp_entry_t                  push_entry;

    // Reserve a slot for every op that will land: buffered + in the MAC + this one, less any pop now.
    assign can_issue = ({1'b0, occ_q} + 3'(pend_valid_q) + 3'd1) <= (3'(BUF_DEPTH) + 3'(pop));

    lcv_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_valid),
        .en_i        (can_issue & ~rst),
        .adv_i       (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    lcv_mac33 u_mac (
        .clk   (clk),
        .rst   (rst),
        .a_i   (a_arr[grant_idx]),
        .b_i   (b_arr[grant_idx]),
        .c_i   (c_arr[grant_idx]),
        .d_i   (d_arr[grant_idx]),
        .e_i   (e_arr[grant_idx]),
        .acc_o (mac_acc)
    );

    assign head_entry = buf_q[head_q];
    assign rsp_valid  = (occ_q != 2'd0) && !rst;
    assign rsp_id     = rsp_valid ? ID_W'(head_entry.id) : '0;
    assign rsp_data   = rsp_valid ? head_entry.data : '0;
    assign busy       = (pend_valid_q || (occ_q != 2'd0)) && !rst;
    assign pop        = rsp_valid && rsp_ready;
    assign push       = pend_valid_q;

    always_comb begin
        pend_valid_d    = accept;
        pend_id_d       = grant_idx;
        occ_d           = occ_q + 2'(push) - 2'(pop);
        head_d          = pop  ? ~head_q : head_q;
        tail_d          = push ? ~tail_q : tail_q;
        push_entry.id   = RSP_ID_MAX_W'(pend_id_q);
        push_entry.data = mac_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            occ_q        <= '0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            if (push) begin
                buf_q[tail_q] <= push_entry;
            end
        end
    end

endmodule

// File: tb/tb_lcv_mul_acc_arbiter.sv
// Directed + randomized check of the shared MAC arbiter against a reference model and scoreboard.
module tb_lcv_mul_acc_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_a = '0, req_b = '0;
    logic [N*33-1:0] req_c = '0, req_d = '0, req_e = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [32:0]     rsp_data;
    logic            busy;

    always #5 clk = ~clk;

    lcv_mul_acc_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d), .req_e(req_e),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    typedef struct {
        int          id;
        logic [32:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    logic [15:0] ta [N];
    logic [15:0] tb_ [N];
    logic [32:0] tc [N];
    logic [32:0] td [N];
    logic [32:0] te [N];
    logic [N-1:0] s_req_ready, s_acc;
    logic        s_rsp_valid, s_busy;
    logic [1:0]  s_rsp_id;
    logic [32:0] s_rsp_data;
    logic        hold_prev = 1'b0;
    logic [34:0] hold_word = '0;

    function automatic logic [32:0] model(input logic signed [15:0] a, input logic signed [15:0] b,
                                          input logic [32:0] c, input logic [32:0] d, input logic [32:0] e);
        longint s;
        s = longint'(a) * longint'(b) + longint'($signed(c)) + longint'($signed(d)) + longint'($signed(e));
        return s[32:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = ta[i];
            req_b[16*i +: 16] = tb_[i];
            req_c[33*i +: 33] = tc[i];
            req_d[33*i +: 33] = td[i];
            req_e[33*i +: 33] = te[i];
        end
    endtask

    task automatic rand_ops(input int i);
        ta[i]  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        tb_[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        tc[i]  = 33'({$urandom, $urandom});
        td[i]  = 33'({$urandom, $urandom});
        te[i]  = 33'({$urandom, $urandom});
    endtask

    // One clock: sample at negedge, score, then return 1 time unit after the next posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        s_req_ready = req_ready;
        s_acc       = req_valid & req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_id    = rsp_id;
        s_rsp_data  = rsp_data;
        s_busy      = busy;
        if (hold_prev && !rst) begin
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_payload", 64'({rsp_id, rsp_data}), 64'(hold_word));
        end
        hold_prev = rsp_valid && !rsp_ready;
        hold_word = {rsp_id, rsp_data};
        if (rsp_valid && rsp_ready) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_unexpected_rsp observed=id%0d expected=no response", rsp_id);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                $display("rsp id=%0d data=%h expected id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_acc[i]) begin
                e.id   = i;
                e.data = model(ta[i], tb_[i], tc[i], td[i], te[i]);
                sb.push_back(e);
                acc_cnt++;
            end
        end
        total++;
        assert (sb.size() <= 2) else begin
            bad++;
            $error("FAIL outstanding observed=%0d expected<=2", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int seq [6];
        logic [32:0] held;
        logic got;
        seq = '{0, 1, 2, 3, 0, 1};

        // Reset behaviour with all requesters asserting
        for (int i = 0; i < N; i++) begin
            ta[i] = 16'(i + 1); tb_[i] = 16'(-(i + 2));
            tc[i] = 33'(100 * i); td[i] = 33'(7); te[i] = 33'(-i);
        end
        drive();
        req_valid = '1;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("rst_req_ready", 64'(s_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(s_rsp_valid), 64'd0);
        chk("rst_busy", 64'(s_busy), 64'd0);
        chk("rst_rsp_id", 64'(s_rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(s_rsp_data), 64'd0);
        req_valid = '0;
        rst = 1'b0;

        // Single request from requester 2
        ta[2] = 16'd3; tb_[2] = 16'hFFFC; tc[2] = 33'd10; td[2] = 33'd1; te[2] = 33'd2;
        drive();
        req_valid = 4'b0100;
        cycle();
        chk("single_ready", 64'(s_req_ready), 64'b0100);
        req_valid = '0;
        cycle();
        chk("single_lat1_valid", 64'(s_rsp_valid), 64'd0);
        chk("single_lat1_busy", 64'(s_busy), 64'd1);
        cycle();
        chk("single_lat2_valid", 64'(s_rsp_valid), 64'd1);
        chk("single_id", 64'(s_rsp_id), 64'd2);
        chk("single_data", 64'(s_rsp_data), 64'd1);
        cycle();
        chk("single_busy_after", 64'(s_busy), 64'd0);

        // Round-robin order from reset at full throughput
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            ta[i] = 16'(i + 1); tb_[i] = 16'(-(i + 2));
            tc[i] = 33'(100 * i); td[i] = 33'(7); te[i] = 33'(-i);
        end
        drive();
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_grant", 64'(s_req_ready), 64'(1 << seq[k]));
            if (k >= 2) chk("rr_rsp_stream", 64'(s_rsp_valid), 64'd1);
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) cycle();
        chk("rr_drained", 64'(sb.size()), 64'd0);

        // Backpressure: two accepts then stall with stable head
        rsp_ready = 1'b0;
        req_valid = '1;
        base = acc_cnt;
        cycle();
        cycle();
        cycle();
        held = s_rsp_data;
        chk("bp_head_valid", 64'(s_rsp_valid), 64'd1);
        cycle();
        cycle();
        chk("bp_accepts", 64'(acc_cnt - base), 64'd2);
        chk("bp_ready_zero", 64'(s_req_ready), 64'd0);
        chk("bp_data_stable", 64'(s_rsp_data), 64'(held));
        rsp_ready = 1'b1;
        base = acc_cnt;
        for (int k = 0; k < 4; k++) cycle();
        total++;
        assert (acc_cnt > base) else begin
            bad++;
            $error("FAIL bp_resume observed=%0d expected>0", acc_cnt - base);
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) cycle();
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Two's-complement wrap at the extremes
        ta[0] = 16'h8000; tb_[0] = 16'h8000;
        tc[0] = 33'h0FFFFFFFF; td[0] = 33'h0FFFFFFFF; te[0] = 33'h0FFFFFFFF;
        drive();
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            cycle();
            if (s_rsp_valid) begin
                got = 1'b1;
                chk("wrap_data", 64'(s_rsp_data), 64'h13FFFFFFD);
                chk("wrap_sign", 64'(s_rsp_data[32]), 64'd1);
            end
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL wrap_timeout observed=no rsp expected=rsp");
        end

        // Reset while an operation is in flight
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rstmid_rsp_valid", 64'(s_rsp_valid), 64'd0);
            chk("rstmid_busy", 64'(s_busy), 64'd0);
        end
        req_valid = '1;
        cycle();
        chk("rstmid_first_grant", 64'(s_req_ready), 64'b0001);
        req_valid = '0;
        for (int k = 0; k < 4; k++) cycle();
        chk("rstmid_drained", 64'(sb.size()), 64'd0);

        // Randomized traffic with random backpressure
        base = acc_cnt;
        for (int cyc = 0; cyc < 4000 && (acc_cnt - base) < 200; cyc++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    rand_ops(i);
                    req_valid[i] = 1'b1;
                end
            end
            drive();
            cycle();
            for (int i = 0; i < N; i++) begin
                if (s_acc[i]) req_valid[i] = 1'b0;
            end
        end
        chk("rand_ops", 64'(acc_cnt - base), 64'd200);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("rand_drained", 64'(sb.size()), 64'd0);
        chk("rand_busy_idle", 64'(s_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
